// File: rtl/riscv_pkg.sv
// Shared definitions for the memory stage: load/store funct3 encodings, FSM states
// and the access-size decode used by the stage and its alignment helper.
package riscv_pkg;

    localparam logic [2:0] LB  = 3'b000;
    localparam logic [2:0] LH  = 3'b001;
    localparam logic [2:0] LW  = 3'b010;
    localparam logic [2:0] LBU = 3'b100;
    localparam logic [2:0] LHU = 3'b101;
    localparam logic [2:0] SB  = 3'b000;
    localparam logic [2:0] SH  = 3'b001;
    localparam logic [2:0] SW  = 3'b010;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } access_size_t;

    // Unlisted funct3 encodings fall back to a full-word access.
    function automatic access_size_t decode_size(input logic [2:0] funct3, input logic is_store);
        access_size_t size;
        size = SIZE_WORD;
        if (is_store) begin
            case (funct3)
                SB:      size = SIZE_BYTE;
                SH:      size = SIZE_HALF;
                SW:      size = SIZE_WORD;
                default: size = SIZE_WORD;
            endcase
        end else begin
            case (funct3)
                LB, LBU: size = SIZE_BYTE;
                LH, LHU: size = SIZE_HALF;
                LW:      size = SIZE_WORD;
                default: size = SIZE_WORD;
            endcase
        end
        return size;
    endfunction

    function automatic logic is_signed_load(input logic [2:0] funct3);
        return (funct3 == LB) || (funct3 == LH);
    endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory valid/ack bus between the memory stage (master) and the memory (slave).
interface mem_access_stage_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        output dmem_wstrb,
        input  dmem_ack,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        input  dmem_wstrb,
        output dmem_ack,
        output dmem_rdata
    );

endinterface

// File: rtl/load_store_align.sv
// Combinational byte-lane logic: store strobes/replication, load lane select with
// sign/zero extension, and misalignment detect (only when MEM_MISALIGN_TRAP_EN is defined).
module load_store_align
    import riscv_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        is_store,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [31:0] load_word,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    access_size_t size;
    logic         sign_ext;
    logic [7:0]   lane [4];
    logic [7:0]   sel_byte;
    logic [15:0]  sel_half;

    assign size     = decode_size(funct3, is_store);
    assign sign_ext = is_signed_load(funct3);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign lane[gi] = load_word[gi*8 +: 8];
        end
    endgenerate

    // Half-word lane is chosen by addr[1] alone; addr[0] is only relevant to the trap check.
    assign sel_byte = lane[offset];
    assign sel_half = offset[1] ? load_word[31:16] : load_word[15:0];

    always_comb begin
        wstrb     = 4'b1111;
        wdata     = store_data;
        load_data = load_word;
        case (size)
            SIZE_BYTE: begin
                wstrb     = 4'b0001 << offset;
                wdata     = {4{store_data[7:0]}};
                load_data = sign_ext ? {{24{sel_byte[7]}}, sel_byte} : {24'h0, sel_byte};
            end
            SIZE_HALF: begin
                wstrb     = offset[1] ? 4'b1100 : 4'b0011;
                wdata     = {2{store_data[15:0]}};
                load_data = sign_ext ? {{16{sel_half[15]}}, sel_half} : {16'h0, sel_half};
            end
            default: begin
                wstrb     = 4'b1111;
                wdata     = store_data;
                load_data = load_word;
            end
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_comb begin
        misaligned = 1'b0;
        case (size)
            SIZE_HALF: misaligned = offset[0];
            SIZE_WORD: misaligned = (offset != 2'b00);
            default:   misaligned = 1'b0;
        endcase
    end
`else
    assign misaligned = 1'b0;
`endif

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline memory stage: drives the valid/ack data bus, stalls upstream while an access is
// outstanding and captures MEM/WB. Optional misaligned-access trap: MEM_MISALIGN_TRAP_EN.
module mem_access_stage
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mem_read_in,
    input  logic                      mem_write_in,
    input  logic                      mem_to_reg_in,
    input  logic                      reg_write_in,
    input  logic [31:0]               alu_result_in,
    input  logic [31:0]               rs2_data_in,
    input  logic [4:0]                rd_in,
    input  logic [2:0]                funct3_in,
    output logic                      stall_out,
    mem_access_stage_if.master        dmem,
    output logic                      reg_write_out,
    output logic                      mem_to_reg_out,
    output logic [4:0]                rd_out,
    output logic [31:0]               alu_result_out,
    output logic [31:0]               mem_data_out,
    output logic                      bus_err_out,
    output logic                      misalign_err_out
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // The abort fires in the WAIT cycle whose miss would bring the count to TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg;

    logic        req_reg, we_reg;
    logic [31:0] addr_reg, wdata_reg;
    logic [3:0]  wstrb_reg;

    logic        reg_write_reg, mem_to_reg_reg, bus_err_reg;
    logic [4:0]  rd_reg;
    logic [31:0] alu_result_reg, mem_data_reg;

    logic [3:0]  align_wstrb;
    logic [31:0] align_wdata, align_load_data;
    logic        misaligned;

    logic access, in_idle, in_wait, start, trap, done, timeout_hit, stall_int, bubble, load_done;

    load_store_align u_align (
        .funct3     (funct3_in),
        .is_store   (mem_write_in),
        .offset     (alu_result_in[1:0]),
        .store_data (rs2_data_in),
        .load_word  (dmem.dmem_rdata),
        .wstrb      (align_wstrb),
        .wdata      (align_wdata),
        .load_data  (align_load_data),
        .misaligned (misaligned)
    );

    assign access      = mem_read_in | mem_write_in;
    assign in_idle     = (state_reg == IDLE);
    assign in_wait     = (state_reg == WAIT);
    assign start       = in_idle && access && !misaligned;
    assign trap        = in_idle && access && misaligned;
    assign done        = in_wait && dmem.dmem_ack;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && in_wait && !dmem.dmem_ack && (cnt_reg == CNT_LAST);
    assign stall_int   = start || (in_wait && !dmem.dmem_ack && !timeout_hit);
    assign stall_out   = stall_int && !reset;
    assign bubble      = stall_int || timeout_hit || trap;
    assign load_done   = done && mem_read_in && !mem_write_in;

    always_ff @(posedge clk) begin
        if (reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = WAIT;
            WAIT:    if (done || timeout_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset || start) begin
            cnt_reg <= '0;
        end else if (in_wait && !dmem.dmem_ack) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    // Bus fields are latched on WAIT entry and held untouched until ack or abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
            addr_reg  <= 32'h0;
            wdata_reg <= 32'h0;
            wstrb_reg <= 4'h0;
        end else if (start) begin
            req_reg   <= 1'b1;
            we_reg    <= mem_write_in;
            addr_reg  <= {alu_result_in[31:2], 2'b00};
            wdata_reg <= align_wdata;
            wstrb_reg <= mem_write_in ? align_wstrb : 4'h0;
        end else if (done || timeout_hit) begin
            req_reg   <= 1'b0;
            we_reg    <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_write_reg  <= 1'b0;
            mem_to_reg_reg <= 1'b0;
            rd_reg         <= 5'd0;
            alu_result_reg <= 32'h0;
            mem_data_reg   <= 32'h0;
            bus_err_reg    <= 1'b0;
        end else begin
            rd_reg         <= rd_in;
            alu_result_reg <= alu_result_in;
            bus_err_reg    <= timeout_hit;
            if (bubble) begin
                reg_write_reg  <= 1'b0;
                mem_to_reg_reg <= 1'b0;
                mem_data_reg   <= 32'h0;
            end else begin
                reg_write_reg  <= reg_write_in;
                mem_to_reg_reg <= mem_to_reg_in;
                mem_data_reg   <= load_done ? align_load_data : 32'h0;
            end
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misalign_err_reg;

    always_ff @(posedge clk) begin
        if (reset) misalign_err_reg <= 1'b0;
        else       misalign_err_reg <= trap;
    end

    assign misalign_err_out = misalign_err_reg;
`else
    assign misalign_err_out = 1'b0;
`endif

    assign dmem.dmem_req   = req_reg;
    assign dmem.dmem_we    = we_reg;
    assign dmem.dmem_addr  = addr_reg;
    assign dmem.dmem_wdata = wdata_reg;
    assign dmem.dmem_wstrb = wstrb_reg;

    assign reg_write_out  = reg_write_reg;
    assign mem_to_reg_out = mem_to_reg_reg;
    assign rd_out         = rd_reg;
    assign alu_result_out = alu_result_reg;
    assign mem_data_out   = mem_data_reg;
    assign bus_err_out    = bus_err_reg;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: the bench plays the data memory, queues the expected
// MEM/WB record per instruction and checks it when the instruction retires.
module tb_mem_access_stage;
    import riscv_pkg::*;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in;
    logic [31:0] alu_result_in, rs2_data_in;
    logic [4:0]  rd_in;
    logic [2:0]  funct3_in;
    logic        stall_out;
    logic        reg_write_out, mem_to_reg_out, bus_err_out, misalign_err_out;
    logic [4:0]  rd_out;
    logic [31:0] alu_result_out, mem_data_out;

    mem_access_stage_if mif();

    mem_access_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk              (clk),
        .reset            (reset),
        .mem_read_in      (mem_read_in),
        .mem_write_in     (mem_write_in),
        .mem_to_reg_in    (mem_to_reg_in),
        .reg_write_in     (reg_write_in),
        .alu_result_in    (alu_result_in),
        .rs2_data_in      (rs2_data_in),
        .rd_in            (rd_in),
        .funct3_in        (funct3_in),
        .stall_out        (stall_out),
        .dmem             (mif),
        .reg_write_out    (reg_write_out),
        .mem_to_reg_out   (mem_to_reg_out),
        .rd_out           (rd_out),
        .alu_result_out   (alu_result_out),
        .mem_data_out     (mem_data_out),
        .bus_err_out      (bus_err_out),
        .misalign_err_out (misalign_err_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rd_en;
        logic        wr_en;
        logic        mtr;
        logic        rw;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
    } instr_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic        chk_data;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
    } bus_t;

    typedef struct packed {
        logic        rw;
        logic        mtr;
        logic [4:0]  rd;
        logic [31:0] alu;
        logic [31:0] data;
        logic        berr;
        logic        merr;
    } wb_t;

    wb_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic instr_t mk_ins(input logic r, input logic w, input logic m, input logic rw,
                                      input logic [31:0] a, input logic [31:0] d,
                                      input logic [4:0] rd, input logic [2:0] f3);
        instr_t t;
        t.rd_en = r; t.wr_en = w; t.mtr = m; t.rw = rw;
        t.addr = a; t.rs2 = d; t.rd = rd; t.f3 = f3;
        return t;
    endfunction

    function automatic bus_t mk_bus(input logic we, input logic [31:0] a, input logic cd,
                                    input logic [3:0] s, input logic [31:0] d);
        bus_t b;
        b.we = we; b.addr = a; b.chk_data = cd; b.wstrb = s; b.wdata = d;
        return b;
    endfunction

    function automatic wb_t mk_wb(input logic rw, input logic m, input logic [4:0] rd,
                                  input logic [31:0] alu, input logic [31:0] data,
                                  input logic berr, input logic merr);
        wb_t w;
        w.rw = rw; w.mtr = m; w.rd = rd; w.alu = alu; w.data = data; w.berr = berr; w.merr = merr;
        return w;
    endfunction

    task automatic drive_nop();
        mem_read_in   = 1'b0;
        mem_write_in  = 1'b0;
        mem_to_reg_in = 1'b0;
        reg_write_in  = 1'b0;
        alu_result_in = 32'h0;
        rs2_data_in   = 32'h0;
        rd_in         = 5'd0;
        funct3_in     = 3'b000;
    endtask

    // Called at a falling edge; returns at the falling edge after the instruction retires.
    task automatic issue(input string name, input instr_t ins, input bus_t bus, input int waitc,
                         input logic [31:0] rdata, input int exp_stall, input int exp_req,
                         input wb_t exp);
        int   req_cyc = 0;
        int   stalls  = 0;
        bit   done    = 1'b0;
        wb_t  want;
        exp_q.push_back(exp);
        mem_read_in   = ins.rd_en;
        mem_write_in  = ins.wr_en;
        mem_to_reg_in = ins.mtr;
        reg_write_in  = ins.rw;
        alu_result_in = ins.addr;
        rs2_data_in   = ins.rs2;
        rd_in         = ins.rd;
        funct3_in     = ins.f3;
        for (int c = 0; c < 40 && !done; c++) begin
            if (mif.dmem_req === 1'b1) begin
                chk32({name, ".addr"}, mif.dmem_addr, bus.addr);
                chk1({name, ".we"}, mif.dmem_we, bus.we);
                if (bus.chk_data) begin
                    chk32({name, ".wstrb"}, 32'(mif.dmem_wstrb), 32'(bus.wstrb));
                    chk32({name, ".wdata"}, mif.dmem_wdata, bus.wdata);
                end
                mif.dmem_ack   = (req_cyc >= waitc);
                mif.dmem_rdata = rdata;
                req_cyc++;
            end else begin
                mif.dmem_ack = 1'b0;
            end
            #1;
            if (stall_out === 1'b1) stalls++;
            else                    done = 1'b1;
            @(negedge clk);
            mif.dmem_ack = 1'b0;
            if (!done) begin
                chk1({name, ".bubble_rw"}, reg_write_out, 1'b0);
                chk32({name, ".bubble_data"}, mem_data_out, 32'h0);
            end
        end
        chk1({name, ".retired"}, done, 1'b1);
        want = exp_q.pop_front();
        chk1({name, ".rw"}, reg_write_out, want.rw);
        chk1({name, ".mtr"}, mem_to_reg_out, want.mtr);
        chk32({name, ".rd"}, 32'(rd_out), 32'(want.rd));
        chk32({name, ".alu"}, alu_result_out, want.alu);
        chk32({name, ".data"}, mem_data_out, want.data);
        chk1({name, ".bus_err"}, bus_err_out, want.berr);
        chk1({name, ".misalign_err"}, misalign_err_out, want.merr);
        chk32({name, ".stall_cycles"}, stalls, exp_stall);
        chk32({name, ".req_cycles"}, req_cyc, exp_req);
        chk1({name, ".req_dropped"}, mif.dmem_req, 1'b0);
        drive_nop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        drive_nop();
        mif.dmem_ack   = 1'b0;
        mif.dmem_rdata = 32'h0;
        mem_read_in    = 1'b1;
        alu_result_in  = 32'h100;
        repeat (3) @(negedge clk);
        #1;
        chk1("reset.stall", stall_out, 1'b0);
        chk1("reset.req", mif.dmem_req, 1'b0);
        chk1("reset.rw", reg_write_out, 1'b0);
        chk32("reset.data", mem_data_out, 32'h0);
        chk1("reset.bus_err", bus_err_out, 1'b0);
        chk1("reset.misalign_err", misalign_err_out, 1'b0);
        drive_nop();
        @(negedge clk);
        reset = 1'b0;

        issue("alu", mk_ins(1'b0, 1'b0, 1'b0, 1'b1, 32'h12345678, 32'h0, 5'd5, 3'b000),
              mk_bus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0), 0, 32'h0, 0, 0,
              mk_wb(1'b1, 1'b0, 5'd5, 32'h12345678, 32'h0, 1'b0, 1'b0));
        issue("lw", mk_ins(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd7, LW),
              mk_bus(1'b0, 32'h100, 1'b0, 4'h0, 32'h0), 0, 32'hDEADBEEF, 1, 1,
              mk_wb(1'b1, 1'b1, 5'd7, 32'h100, 32'hDEADBEEF, 1'b0, 1'b0));
        issue("lb", mk_ins(1'b1, 1'b0, 1'b1, 1'b1, 32'h103, 32'h0, 5'd8, LB),
              mk_bus(1'b0, 32'h100, 1'b0, 4'h0, 32'h0), 0, 32'h80FFFFFF, 1, 1,
              mk_wb(1'b1, 1'b1, 5'd8, 32'h103, 32'hFFFFFF80, 1'b0, 1'b0));
        issue("lbu", mk_ins(1'b1, 1'b0, 1'b1, 1'b1, 32'h103, 32'h0, 5'd9, LBU),
              mk_bus(1'b0, 32'h100, 1'b0, 4'h0, 32'h0), 0, 32'h80FFFFFF, 1, 1,
              mk_wb(1'b1, 1'b1, 5'd9, 32'h103, 32'h00000080, 1'b0, 1'b0));
        issue("lh", mk_ins(1'b1, 1'b0, 1'b1, 1'b1, 32'h102, 32'h0, 5'd10, LH),
              mk_bus(1'b0, 32'h100, 1'b0, 4'h0, 32'h0), 0, 32'h80011234, 1, 1,
              mk_wb(1'b1, 1'b1, 5'd10, 32'h102, 32'hFFFF8001, 1'b0, 1'b0));
        issue("lhu", mk_ins(1'b1, 1'b0, 1'b1, 1'b1, 32'h100, 32'h0, 5'd11, LHU),
              mk_bus(1'b0, 32'h100, 1'b0, 4'h0, 32'h0), 0, 32'h8001F234, 1, 1,
              mk_wb(1'b1, 1'b1, 5'd11, 32'h100, 32'h0000F234, 1'b0, 1'b0));
        issue("sh", mk_ins(1'b0, 1'b1, 1'b0, 1'b0, 32'h202, 32'h1234ABCD, 5'd0, SH),
              mk_bus(1'b1, 32'h200, 1'b1, 4'b1100, 32'hABCDABCD), 0, 32'h0, 1, 1,
              mk_wb(1'b0, 1'b0, 5'd0, 32'h202, 32'h0, 1'b0, 1'b0));
        issue("sb", mk_ins(1'b0, 1'b1, 1'b0, 1'b0, 32'h301, 32'h000000A5, 5'd0, SB),
              mk_bus(1'b1, 32'h300, 1'b1, 4'b0010, 32'hA5A5A5A5), 0, 32'h0, 1, 1,
              mk_wb(1'b0, 1'b0, 5'd0, 32'h301, 32'h0, 1'b0, 1'b0));
        issue("sw_wait1", mk_ins(1'b0, 1'b1, 1'b0, 1'b0, 32'h40C, 32'hCAFEF00D, 5'd0, SW),
              mk_bus(1'b1, 32'h40C, 1'b1, 4'b1111, 32'hCAFEF00D), 1, 32'h0, 2, 2,
              mk_wb(1'b0, 1'b0, 5'd0, 32'h40C, 32'h0, 1'b0, 1'b0));
        // Ack lands in the fourth WAIT cycle, the same cycle the timeout would fire.
        issue("lw_wait3", mk_ins(1'b1, 1'b0, 1'b1, 1'b1, 32'h104, 32'h0, 5'd12, LW),
              mk_bus(1'b0, 32'h104, 1'b0, 4'h0, 32'h0), 3, 32'h13579BDF, 4, 4,
              mk_wb(1'b1, 1'b1, 5'd12, 32'h104, 32'h13579BDF, 1'b0, 1'b0));
        issue("lw_timeout", mk_ins(1'b1, 1'b0, 1'b1, 1'b1, 32'h108, 32'h0, 5'd13, LW),
              mk_bus(1'b0, 32'h108, 1'b0, 4'h0, 32'h0), 100, 32'h0, 4, 4,
              mk_wb(1'b0, 1'b0, 5'd13, 32'h108, 32'h0, 1'b1, 1'b0));
        issue("after_timeout", mk_ins(1'b0, 1'b0, 1'b0, 1'b1, 32'h55, 32'h0, 5'd14, 3'b000),
              mk_bus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0), 0, 32'h0, 0, 0,
              mk_wb(1'b1, 1'b0, 5'd14, 32'h55, 32'h0, 1'b0, 1'b0));
        issue("rd_and_wr", mk_ins(1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 32'h11112222, 5'd0, SW),
              mk_bus(1'b1, 32'h500, 1'b1, 4'b1111, 32'h11112222), 0, 32'hFFFFFFFF, 1, 1,
              mk_wb(1'b0, 1'b0, 5'd0, 32'h500, 32'h0, 1'b0, 1'b0));
`ifdef MEM_MISALIGN_TRAP_EN
        issue("lw_misaligned", mk_ins(1'b1, 1'b0, 1'b1, 1'b1, 32'h101, 32'h0, 5'd6, LW),
              mk_bus(1'b0, 32'h100, 1'b0, 4'h0, 32'h0), 0, 32'h0BADF00D, 0, 0,
              mk_wb(1'b0, 1'b0, 5'd6, 32'h101, 32'h0, 1'b0, 1'b1));
`else
        issue("lw_unaligned", mk_ins(1'b1, 1'b0, 1'b1, 1'b1, 32'h101, 32'h0, 5'd6, LW),
              mk_bus(1'b0, 32'h100, 1'b0, 4'h0, 32'h0), 0, 32'h0BADF00D, 1, 1,
              mk_wb(1'b1, 1'b1, 5'd6, 32'h101, 32'h0BADF00D, 1'b0, 1'b0));
`endif

        // Reset in the middle of an outstanding load, then a stray ack while IDLE.
        mem_read_in   = 1'b1;
        mem_to_reg_in = 1'b1;
        reg_write_in  = 1'b1;
        alu_result_in = 32'h600;
        rd_in         = 5'd3;
        funct3_in     = LW;
        @(negedge clk);
        chk1("midreset.req_before", mif.dmem_req, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk1("midreset.req_after", mif.dmem_req, 1'b0);
        chk1("midreset.stall", stall_out, 1'b0);
        reset = 1'b0;
        drive_nop();
        reg_write_in   = 1'b1;
        rd_in          = 5'd4;
        alu_result_in  = 32'h77;
        mif.dmem_ack   = 1'b1;
        mif.dmem_rdata = 32'hFFFF0000;
        #1;
        chk1("idle_ack.stall", stall_out, 1'b0);
        @(negedge clk);
        mif.dmem_ack = 1'b0;
        chk1("idle_ack.req", mif.dmem_req, 1'b0);
        chk1("idle_ack.rw", reg_write_out, 1'b1);
        chk32("idle_ack.data", mem_data_out, 32'h0);
        chk32("idle_ack.rd", 32'(rd_out), 32'd4);
        drive_nop();

        issue("lw_post_reset", mk_ins(1'b1, 1'b0, 1'b1, 1'b1, 32'h700, 32'h0, 5'd15, LW),
              mk_bus(1'b0, 32'h700, 1'b0, 4'h0, 32'h0), 0, 32'h2468ACE0, 1, 1,
              mk_wb(1'b1, 1'b1, 5'd15, 32'h700, 32'h2468ACE0, 1'b0, 1'b0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the 5-stage pipeline, directly downstream of the EX/MEM register. Consumes the registered EX/MEM control and data and performs loads and stores over a valid/ack data-memory bus. Produces byte/half/word alignment and sign/zero extension, and stalls the upstream pipeline while an access is outstanding. Captures results into its internal MEM/WB register for the write-back stage.

## Interface
- TIMEOUT_CYCLES, 255: maximum cycles waiting for `dmem_ack` before the access is aborted; 0 disables the timeout.
- Reset is synchronous and active-high; one clock domain.
- clk  in  1  pipeline clock
- reset  in  1  synchronous, active-high reset
- mem_read_in, mem_write_in, mem_to_reg_in, reg_write_in  in  1 each  EX/MEM control
- alu_result_in  in  32  effective address / ALU result
- rs2_data_in  in  32  store data
- rd_in  in  5  destination register
- funct3_in  in  3  access size/sign (EX/MEM carries this field)
- stall_out  out  1  hold EX/MEM and earlier stages (combinational)
- dmem_req  out  1  access request (registered)
- dmem_we  out  1  1 = store
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte strobes
- dmem_ack  in  1  access complete; `dmem_rdata` is valid when this is high
- dmem_rdata  in  32  read word
- reg_write_out, mem_to_reg_out  out  1 each  MEM/WB control
- rd_out  out  5  MEM/WB destination
- alu_result_out  out  32  MEM/WB ALU result
- mem_data_out  out  32  extended load data; 0 for non-loads
- bus_err_out  out  1  one-cycle pulse on timeout abort
- misalign_err_out  out  1  one-cycle pulse on misaligned access (tied 0 without macro)

## Operation
- FSM states:
  - IDLE: in IDLE, an access (`mem_read_in` or `mem_write_in`) goes to WAIT. `mem_write_in` wins if both are set.
  - WAIT: holds `dmem_req`, `dmem_we`, `dmem_addr`, `dmem_wdata`, `dmem_wstrb` stable until ack or timeout.
- `stall_out` = (IDLE && access && !misaligned) || (WAIT && !dmem_ack && !timeout).
- Bubble: every MEM/WB capture while stalled forces `reg_write_out`=0, `mem_to_reg_out`=0 and `mem_data_out`=0.
- Completion: ack in WAIT captures the real instruction into MEM/WB and returns the FSM to IDLE.
- Non-memory instructions pass to MEM/WB in 1 cycle with no stall.
- Loads, with lane offset o = addr[1:0]:
  - funct3 000/100: LB/LBU byte at o.
  - funct3 001/101: LH/LHU half at addr[1].
  - funct3 010: LW. Other funct3 values are treated as a word access.
  - Sign-extend for 000/001; zero-extend for 100/101.
- Stores:
  - SB: wstrb = 4'b0001<<o, byte replicated x4.
  - SH: wstrb 0011 or 1100, half replicated x2.
  - SW: wstrb 1111.
- Timeout: a counter clears on WAIT entry and increments each WAIT cycle without ack. When it reaches TIMEOUT_CYCLES:
  - `dmem_req` drops, FSM goes to IDLE, `stall_out` releases.
  - The instruction retires with `reg_write_out`=0 and `bus_err_out`=1 for one cycle.
- `dmem_ack` in IDLE is ignored.
- Ack in the same cycle as the timeout is treated as a completed access (ack wins).

## Timing
- Reset values: FSM IDLE, counter 0, all outputs 0 (including `dmem_req` and `stall_out` while `reset` is high).
- Reset mid-access: `dmem_req` is low after the reset edge; a later ack is ignored.
- Load/store latency with zero-wait memory:
  - Cycle N: instruction presented, `stall_out`=1.
  - Cycle N+1: `dmem_req`=1 and ack.
  - MEM/WB valid after edge N+1, giving 1 stall cycle.
- Each extra wait cycle adds one stall cycle.
- `dmem_req` rises only at a clock edge and falls on the edge after ack/timeout; a back-to-back access re-enters WAIT via IDLE.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A misaligned LH/LHU/SH (addr[0]) or LW/SW (addr[1:0]!=0) issues no bus request and does not stall.
  - It retires in 1 cycle with `reg_write_out`=0 and `misalign_err_out`=1 for one cycle.
- Undefined: no misalignment check; halfword uses addr[1] only and word ignores addr[1:0]; `misalign_err_out` is constant 0.

## Structure
- Package `riscv_pkg`: funct3 constants (LB, LH, LW, LBU, LHU, SB, SH, SW), FSM state enum.
- Sub-module `load_store_align`: combinational strobe generation, store data replication, load lane select and extension, misalignment detect. The FSM, timeout counter and MEM/WB register stay in the top module.

## Test plan
- LW at 0x100, memory returns 0xDEADBEEF with zero wait -> one stall cycle; `mem_data_out`=0xDEADBEEF, `rd_out` correct, `reg_write_out`=1.
- LB at 0x103, rdata 0x80FFFFFF -> `mem_data_out`=0xFFFFFF80; LBU same -> 0x00000080.
- SH at 0x202, rs2 0x1234ABCD -> `dmem_wstrb`=1100, `dmem_wdata`=0xABCDABCD, `dmem_addr`=0x200.
- Ack after 3 wait cycles -> `stall_out` high 4 cycles; bubbles in MEM/WB (`reg_write_out`=0) until completion.
- TIMEOUT_CYCLES=4, no ack -> `dmem_req` drops after 4 WAIT cycles; `bus_err_out` pulses; `reg_write_out`=0.
- `MEM_MISALIGN_TRAP_EN`, LW at 0x101 -> no `dmem_req`, no stall, `misalign_err_out`=1; `reset` asserted mid-WAIT -> `dmem_req`=0 next cycle.
